// File: rtl/wb_spi_cfg_master_pkg.sv
// Shared constants for the Wishbone-to-SPI configuration master.
// Holds register map, bit positions and FSM encoding.
package wb_spi_cfg_master_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CSHOLD = 1;
  localparam int CTRL_IRQEN  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SCK_LO,
    S_SCK_HI,
    S_TRAIL
  } spi_state_e;

endpackage

// File: rtl/wb_spi_cfg_master_clk_div.sv
// Half-period timer: tick on every (div+1)th clock, held at zero while restart is high.
module spi_clk_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == div);
    cnt_d = cnt_q + 8'd1;
    // The FSM changes state on every tick, so wrapping here restarts each state
    if (restart || tick) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_spi_cfg_master.sv
// Wishbone slave with CTRL/DIV/DATA/STATUS registers driving a 32-bit
// mode-0 SPI master toward the motor core.
module wb_spi_cfg_master
  import wb_spi_cfg_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  DIV_RESET = 8'd4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        busy_o,
  output logic        irq_o
);

  spi_state_e  state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  div_q, div_d;
  logic [31:0] tx_q, tx_d, rx_q, rx_d;
  logic [31:0] sh_q, sh_d, rxsh_q, rxsh_d;
  logic [4:0]  bit_q, bit_d;
  logic        done_q, done_d, ovr_q, ovr_d;
  logic        start_q, start_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        csn_q, csn_d, sck_q, sck_d;

  logic        tick, acc, wr, rd, busy_int, abort;
  logic [1:0]  rsel;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

  spi_clk_div u_div (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .restart (state_q == S_IDLE),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    acc      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    wr       = acc & wbs_we_i;
    rd       = acc & ~wbs_we_i;
    rsel     = wbs_adr_i[3:2];
    // A start already committed but not yet in LEAD still counts as busy
    busy_int = (state_q != S_IDLE) | start_q;
    abort    = (state_q != S_IDLE) & ~ctrl_q[CTRL_EN];

    ctrl_d  = ctrl_q;
    div_d   = div_q;
    tx_d    = tx_q;
    start_d = 1'b0;
    done_d  = done_q;
    ovr_d   = ovr_q;
    ack_d   = acc;
    dat_d   = 32'd0;

    if (rd) begin
      case (rsel)
        REG_CTRL:   dat_d = {29'd0, ctrl_q};
        REG_DIV:    dat_d = {24'd0, div_q};
        REG_DATA:   dat_d = rx_q;
        default:    dat_d = {29'd0, ovr_q, done_q, state_q != S_IDLE};
      endcase
    end

    if (wr) begin
      case (rsel)
        REG_CTRL: if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[2:0];
        REG_DIV:  if (wbs_sel_i[0] && !busy_int) div_d = wbs_dat_i[7:0];
        REG_DATA: begin
          if (busy_int) ovr_d = 1'b1;
          else begin
            tx_d    = wbs_dat_i;
            start_d = ctrl_q[CTRL_EN];
          end
        end
        default: if (wbs_sel_i[0]) begin
          if (wbs_dat_i[STAT_DONE]) done_d = 1'b0;
          if (wbs_dat_i[STAT_OVR])  ovr_d  = 1'b0;
        end
      endcase
    end

    state_d = state_q;
    sh_d    = sh_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    csn_d   = csn_q;

    if (abort) begin
      state_d = S_IDLE;
      csn_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_q) begin
            state_d = S_LEAD;
            sh_d    = tx_q;
            bit_d   = 5'(WORD_LEN - 1);
            csn_d   = 1'b0;
          end else if (!ctrl_q[CTRL_CSHOLD]) begin
            csn_d = 1'b1;
          end
        end
        S_LEAD:   if (tick) state_d = S_SCK_LO;
        S_SCK_LO: if (tick) begin
          state_d = S_SCK_HI;
          rxsh_d  = {rxsh_q[30:0], spi_cipo_i};
        end
        S_SCK_HI: if (tick) begin
          if (bit_q == 5'd0) state_d = S_TRAIL;
          else begin
            state_d = S_SCK_LO;
            sh_d    = {sh_q[30:0], 1'b0};
            bit_d   = bit_q - 5'd1;
          end
        end
        S_TRAIL: if (tick) begin
          state_d = S_IDLE;
          rx_d    = rxsh_q;
          done_d  = 1'b1;
          csn_d   = ~ctrl_q[CTRL_CSHOLD];
        end
        default: state_d = S_IDLE;
      endcase
    end

    sck_d = (state_d == S_SCK_HI);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ctrl_q  <= 3'd0;
      div_q   <= DIV_RESET;
      tx_q    <= 32'd0;
      rx_q    <= 32'd0;
      sh_q    <= 32'd0;
      rxsh_q  <= 32'd0;
      bit_q   <= 5'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sh_q    <= sh_d;
      rxsh_q  <= rxsh_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign spi_sck_o  = sck_q;
  assign spi_csn_o  = csn_q;
  assign spi_copi_o = (state_q != S_IDLE) & sh_q[31];
  assign busy_o     = (state_q != S_IDLE);
  assign irq_o      = done_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_wb_spi_cfg_master.sv
// Directed + randomized bench for wb_spi_cfg_master with a word-level SPI slave model.
module tb_wb_spi_cfg_master;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_DIV = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8, A_STAT = BASE + 32'hC;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, sck, csn, copi, busy, irq;
  logic [31:0] dat_o;
  logic        cipo;

  int n_chk = 0, n_fail = 0;

  // slave model: loopback, or present cipo_word MSB first, one bit per SCK pulse
  logic        loop_m = 1'b1;
  logic [31:0] cipo_word = '0;
  int          pulse_total = 0, pulse_base = 0, csn_hi_total = 0;
  logic [31:0] cap = '0;

  always #5 clk = ~clk;

  wb_spi_cfg_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .spi_sck_o(sck), .spi_csn_o(csn), .spi_copi_o(copi), .spi_cipo_i(cipo),
    .busy_o(busy), .irq_o(irq)
  );

  always @(posedge sck) begin
    cap         = {cap[30:0], copi};
    pulse_total = pulse_total + 1;
  end

  always @(negedge clk) if (csn) csn_hi_total = csn_hi_total + 1;

  always_comb begin
    cipo = copi;
    if (!loop_m) cipo = ((pulse_total - pulse_base) < 32) ? cipo_word[31 - (pulse_total - pulse_base)] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic got);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = 4'hF;
    got = 1'b0; r = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; r = dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic got;
    wb_acc(1'b1, a, d, r, got);
    chk("wr_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    logic got;
    wb_acc(1'b0, a, 32'd0, r, got);
    chk("rd_ack", {31'd0, got}, 32'd1);
  endtask

  // start a transfer and count cycles with busy high until it drops
  task automatic xfer(input logic [31:0] tx, output int nbusy);
    pulse_base = pulse_total;
    wr(A_DATA, tx);
    nbusy = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      else if (nbusy > 0) break;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, tx, rx_prev, t1;
    logic        got;
    int          nb, dv, hi0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", {31'd0, csn}, 32'd1);
    chk("rst_outs", {26'd0, sck, copi, ack, busy, irq, 1'b0}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst = 1'b0;
    rd(A_DIV, r);  chk("rst_div", r, 32'd4);
    rd(A_CTRL, r); chk("rst_ctrl", r, 32'd0);
    rd(A_STAT, r); chk("rst_stat", r, 32'd0);
    rd(A_DATA, r); chk("rst_rx", r, 32'd0);
    @(posedge clk); #1; chk("ack_one_cycle", {31'd0, ack}, 32'd0);

    // DIV=0 loopback
    wr(A_CTRL, 32'h1);
    wr(A_DIV, 32'h0);
    loop_m = 1'b1;
    xfer(32'hA5A5_0F0F, nb);
    chk("d0_busy", nb, 66);
    chk("d0_pulses", pulse_total - pulse_base, 32);
    chk("d0_copi", cap, 32'hA5A5_0F0F);
    chk("d0_csn", {31'd0, csn}, 32'd1);
    rd(A_DATA, r); chk("d0_rx", r, 32'hA5A5_0F0F);
    rd(A_STAT, r); chk("d0_stat", r, 32'h2);
    rx_prev = 32'hA5A5_0F0F;

    // random words against the slave model
    loop_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv = $urandom_range(0, 3);
      tx = $urandom;
      cipo_word = $urandom;
      wr(A_DIV, dv);
      wr(A_STAT, 32'h6);
      rd(A_STAT, r); chk("rnd_clr", r, 32'h0);
      xfer(tx, nb);
      chk("rnd_busy", nb, 66 * (dv + 1));
      chk("rnd_pulses", pulse_total - pulse_base, 32);
      chk("rnd_copi", cap, tx);
      rd(A_DATA, r); chk("rnd_rx", r, cipo_word);
      rd(A_STAT, r); chk("rnd_done", r, 32'h2);
      rx_prev = cipo_word;
    end

    // chip-select hold across two transfers
    loop_m = 1'b1;
    wr(A_DIV, 32'd3);
    wr(A_CTRL, 32'h3);
    pulse_base = pulse_total;
    wr(A_DATA, 32'h1234_5678);
    @(posedge clk); #1;
    hi0 = csn_hi_total;
    wait_idle();
    chk("hold_csn_gap", {31'd0, csn}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    xfer(32'h8765_4321, nb);
    chk("hold_busy2", nb, 264);
    chk("hold_csn_low", csn_hi_total - hi0, 0);
    chk("hold_copi2", cap, 32'h8765_4321);
    wr(A_CTRL, 32'h1);
    chk("hold_release_early", {31'd0, csn}, 32'd0);
    @(posedge clk); #1;
    chk("hold_release", {31'd0, csn}, 32'd1);
    rx_prev = 32'h8765_4321;

    // overrun: second DATA write 10 clocks in
    wr(A_DIV, 32'd0);
    wr(A_STAT, 32'h6);
    t1 = $urandom;
    pulse_base = pulse_total;
    wr(A_DATA, t1);
    repeat (9) @(posedge clk);
    #1;
    wr(A_DATA, ~t1);
    rd(A_STAT, r); chk("ovr_stat", r, 32'h5);
    wait_idle();
    chk("ovr_pulses", pulse_total - pulse_base, 32);
    chk("ovr_copi", cap, t1);
    rd(A_DATA, r); chk("ovr_rx", r, t1);
    rx_prev = t1;

    // abort by clearing enable mid-transfer
    wr(A_DIV, 32'd1);
    wr(A_STAT, 32'h6);
    wr(A_DATA, 32'hDEAD_BEEF);
    repeat (19) @(posedge clk);
    #1;
    wr(A_CTRL, 32'h0);
    @(posedge clk); #1;
    chk("abort_csn", {31'd0, csn}, 32'd1);
    chk("abort_sck_busy", {30'd0, sck, busy}, 32'd0);
    rd(A_STAT, r); chk("abort_stat", r, 32'h0);
    rd(A_DATA, r); chk("abort_rx", r, rx_prev);

    // DATA write with enable clear does not start
    pulse_base = pulse_total;
    wr(A_DATA, 32'h5555_AAAA);
    repeat (4) @(posedge clk);
    #1;
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_pulses", pulse_total - pulse_base, 0);

    // unmapped address gets no ack
    wb_acc(1'b0, BASE + 32'h10, 32'd0, r, got);
    chk("unsel_noack", {31'd0, got}, 32'd0);

    // interrupt
    wr(A_CTRL, 32'h5);
    xfer(32'h0F0F_F0F0, nb);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(A_STAT, 32'h2);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // reset mid-transfer
    wr(A_DIV, 32'd2);
    wr(A_DATA, 32'hC3C3_3C3C);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_csn", {31'd0, csn}, 32'd1);
    chk("mrst_outs", {26'd0, sck, copi, ack, busy, irq, 1'b0}, 32'd0);
    chk("mrst_dat", dat_o, 32'd0);
    nb = pulse_total;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_sck", pulse_total - nb, 0);
    rst = 1'b0;
    rd(A_DIV, r);  chk("mrst_div", r, 32'd4);
    rd(A_DATA, r); chk("mrst_rx", r, 32'd0);
    rd(A_STAT, r); chk("mrst_stat", r, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_spi_cfg_master.md
WB_SPI_CFG_MASTER -- requirements
Module: wb_spi_cfg_master

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base; the block decodes adr[31:4].
REQ-002 The block SHALL have parameter DIV_RESET, default 8'd4: reset value of the DIV register.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each input, 1 bit: Wishbone slave strobe, cycle and write.
REQ-006 The block SHALL have ports wbs_sel_i, input, 4 bits; wbs_dat_i, input, 32 bits; wbs_adr_i, input, 32 bits.
REQ-007 The block SHALL have ports wbs_ack_o, output, 1 bit, and wbs_dat_o, output, 32 bits.
REQ-008 The block SHALL have ports spi_sck_o, spi_csn_o and spi_copi_o, each output, 1 bit: SPI master to the motor core's SCK/CS/COPI; spi_csn_o is active-low.
REQ-009 The block SHALL have port spi_cipo_i, input, 1 bit: SPI data from the motor core.
REQ-010 The block SHALL have ports busy_o, output, 1 bit (transfer in progress), and irq_o, output, 1 bit (done AND CTRL.irq_en).

Function
REQ-011 The block SHALL treat an access as selected when cyc&stb and adr[31:4]==BASE_ADDR[31:4]; register select is adr[3:2].
REQ-012 Register 0x0 CTRL SHALL have bit0 enable, bit1 cs_hold and bit2 irq_en; writes SHALL honour byte lane sel[0].
REQ-013 Register 0x4 DIV[7:0] SHALL set the SCK half-period to DIV+1 clocks; writes SHALL honour sel[0] and be ignored while busy.
REQ-014 Register 0x8 DATA: a write SHALL load the 32-bit TX word and start a transfer, with sel ignored; a read SHALL return the last RX word.
REQ-015 Register 0xC STATUS SHALL have bit0 busy, bit1 done (write-1-to-clear) and bit2 overrun (write-1-to-clear).
REQ-016 The block SHALL drive wbs_ack_o high for exactly one cycle, registered, in the cycle after a selected access with ack low; unselected accesses SHALL never be acked; read data SHALL be valid with ack.
REQ-017 The FSM SHALL have states IDLE, LEAD, SCK_LO, SCK_HI and TRAIL.
REQ-018 IDLE->LEAD SHALL occur on the cycle after a DATA write ack when enable=1 and not busy; in LEAD, spi_csn_o=0 and COPI=TX[31] for DIV+1 clocks.
REQ-019 Transfers SHALL be SPI mode 0, MSB first, 32 bits: SCK_HI lasts DIV+1 clocks, sampling CIPO on the rising edge; SCK_LO lasts DIV+1 clocks, shifting COPI on the falling edge.
REQ-020 After bit 0's SCK_HI, the FSM SHALL go to TRAIL with SCK low for DIV+1 clocks, then IDLE.
REQ-021 The busy duration SHALL be exactly (DIV+1)*66 clocks.
REQ-022 On TRAIL exit the block SHALL latch RX, set done, and deassert busy in the same cycle.
REQ-023 spi_csn_o SHALL return high at TRAIL exit if cs_hold=0; otherwise it SHALL stay low until cs_hold is written 0 while idle, rising the following cycle.
REQ-024 A DATA write while busy SHALL be acked, the TX word not altered, the transfer not restarted, and overrun set.
REQ-025 A DATA write with enable=0 SHALL be acked and no transfer SHALL start.
REQ-026 Clearing enable mid-transfer SHALL abort: the FSM goes to IDLE next cycle, spi_csn_o=1, SCK=0, done is not set, and RX is unchanged.
REQ-027 When a done-set and a W1C clear of done occur in the same cycle, the set SHALL win.

Reset
REQ-028 On wb_rst_i the block SHALL immediately set: FSM=IDLE, spi_csn_o=1, spi_sck_o=0, spi_copi_o=0, wbs_ack_o=0, wbs_dat_o=0, busy_o=0, irq_o=0, CTRL=0, DIV=DIV_RESET, TX=0, RX=0, STATUS=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no further SCK edges.

Structure
REQ-030 A shared package SHALL hold the register offsets, CTRL/STATUS bit indices, the FSM state encoding and the word length constant 32.
REQ-031 The block SHALL have one sub-module, spi_clk_div: the half-period counter issuing a tick every DIV+1 clocks, restarted on each state entry.

Verification
REQ-032 The bench SHALL check: DIV=0, write DATA=32'hA5A5_0F0F, CIPO looped to COPI -> 32 SCK pulses, busy for 66 clocks, RX=32'hA5A5_0F0F, done=1.
REQ-033 The bench SHALL check: DIV=3, cs_hold=1, two DATA writes -> spi_csn_o low throughout both; writing cs_hold=0 -> spi_csn_o high one cycle later.
REQ-034 The bench SHALL check: DATA write 10 clocks into a transfer -> ack, overrun=1, first TX word fully shifted.
REQ-035 The bench SHALL check: enable cleared at clock 20 of a transfer -> spi_csn_o=1 next cycle, done=0, RX unchanged.
REQ-036 The bench SHALL check: wb_rst_i pulse mid-transfer -> all outputs at their reset values immediately, DIV reads 4.
REQ-037 The bench SHALL check: read at BASE_ADDR+0x10 -> no ack; irq_en=1 with a transfer complete -> irq_o=1, and W1C of done -> irq_o=0.
